lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter T_PWR, default 750000, meaning power-up wait in clk cycles (≥1).
REQ-002 SHALL have parameter T_SETUP, default 3, meaning RS/DATA setup before EN rise in cycles (≥1).
REQ-003 SHALL have parameter T_PULSE, default 12, meaning EN high width in cycles (≥1).
REQ-004 SHALL have parameter T_HOLD, default 3, meaning RS/DATA hold after EN fall in cycles (≥1).
REQ-005 SHALL have parameter T_CMD, default 2500, meaning post-write wait for normal commands/data in cycles (≥1).
REQ-006 SHALL have parameter T_LONG, default 82000, meaning post-write wait for clear/home in cycles (≥1).
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-009 SHALL have port i_valid, input, 1, meaning write request present.
REQ-010 SHALL have port o_ready, output, 1, meaning controller can accept a request.
REQ-011 SHALL have port i_rs, input, 1, meaning register select: 0 command, 1 data.
REQ-012 SHALL have port i_data, input, 8, meaning byte to write.
REQ-013 SHALL have port o_init_done, output, 1, meaning power-up init sequence complete.
REQ-014 SHALL have port o_lcd, output, 32, meaning LCD pin word: [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA; all other bits 0.

Function
REQ-015 SHALL use states PWRUP, SETUP, PULSE, HOLD, WAIT, IDLE, with a 4-entry init index (0..3) and one down-counter shared by all timed states.
REQ-016 SHALL make each timed state last exactly its parameter N cycles: counter loads N-1 on entry, state exits on the cycle the counter is 0.
REQ-017 SHALL drive o_lcd[8] (RW) to 0 at all times; the block is write-only.
REQ-018 SHALL drive o_lcd[31] (ON) to 1 in every state after reset release.
REQ-019 SHALL, after T_PWR cycles in PWRUP, issue init commands in order 0x38, 0x0C, 0x01, 0x06 with RS=0, each through SETUP→PULSE→HOLD→WAIT.
REQ-020 SHALL assert o_init_done=1 and enter IDLE after the WAIT of command 0x06; o_init_done SHALL remain 1 until reset.
REQ-021 SHALL assert o_ready=1 only in IDLE; o_ready SHALL be combinational from state only, never dependent on i_valid.
REQ-022 SHALL accept a request on a cycle with i_valid=1 and o_ready=1, register i_rs/i_data, and enter SETUP on the next cycle.
REQ-023 SHALL ignore i_valid, i_rs and i_data whenever o_ready=0; no queuing and no request loss is reported.
REQ-024 SHALL hold registered RS on o_lcd[9] and DATA on o_lcd[7:0] unchanged through SETUP, PULSE, HOLD and WAIT.
REQ-025 SHALL drive EN (o_lcd[10]) to 1 only in PULSE.
REQ-026 SHALL place the EN rising edge exactly T_SETUP+1 cycles after the accept edge.
REQ-027 SHALL select T_LONG for WAIT when RS=0 and DATA is 0x01, 0x02 or 0x03, and T_CMD otherwise.
REQ-028 SHALL return to IDLE after WAIT, so a back-to-back request is accepted on the first IDLE cycle.
REQ-029 SHALL make minimum accept-to-accept spacing T_SETUP+T_PULSE+T_HOLD+Twait+1 cycles.
REQ-030 SHALL size the counter to hold max(T_PWR, T_LONG)-1 without overflow; no wrap-around is permitted.

Reset
REQ-031 SHALL, while rst=0, force o_lcd=0, o_ready=0, o_init_done=0, state=PWRUP, init index=0, counter=T_PWR-1, and captured RS/DATA=0.
REQ-032 SHALL, on rst asserted mid-operation (including EN high), drop all outputs to reset values immediately and restart the full power-up sequence after release.

Verification
Parameters for all scenarios: T_PWR=10, T_SETUP=2, T_PULSE=3, T_HOLD=2, T_CMD=5, T_LONG=20.
REQ-033 SHALL cover init: release reset → ON=1, four EN pulses of 3 cycles with DATA 0x38, 0x0C, 0x01, 0x06; 20-cycle wait after 0x01; o_init_done and o_ready rise together after the final 5-cycle wait.
REQ-034 SHALL cover a data write: accept RS=1, DATA=0x41 → EN high exactly 3 cycles, rising 3 cycles after accept; RS=1 and DATA=0x41 stable throughout; o_ready returns 12 cycles after accept.
REQ-035 SHALL cover a clear command: accept RS=0, DATA=0x01 → WAIT lasts 20 cycles; o_ready returns 27 cycles after accept.
REQ-036 SHALL cover ignored input: i_valid held high with changing DATA while busy → only the byte present at the accept cycle appears on o_lcd[7:0]; the next accept occurs on the first IDLE cycle.
REQ-037 SHALL cover reset during PULSE: assert rst while EN=1 → o_lcd=0 and o_init_done=0 immediately; after release, the full init sequence repeats from 0x38.
REQ-038 SHALL cover the RW/unused-bit check: across all scenarios, o_lcd[8]=0 and o_lcd[30:11]=0 every cycle.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write controller: power-up wait, 4-command init, then paced single-byte writes.
// Latency: EN rises T_SETUP+1 cycles after accept; ready again T_SETUP+T_PULSE+T_HOLD+Twait cycles after accept.
// Backpressure: o_ready is high only in IDLE; requests presented while busy are ignored, not queued.
module lcd_ctrl #(
  parameter int T_PWR   = 750000,
  parameter int T_SETUP = 3,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 3,
  parameter int T_CMD   = 2500,
  parameter int T_LONG  = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_rs,
  input  logic [7:0]  i_data,
  output logic        o_init_done,
  output logic [31:0] o_lcd
);

  // The shared counter must hold the longest load value (max-1) without wrapping.
  localparam int T_MAX = (T_PWR > T_LONG) ? T_PWR : T_LONG;
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    init_idx, init_idx_nxt;
  logic          rs_q, rs_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          init_done_q, init_done_nxt;
  logic [31:0]   lcd_q;
  logic          cnt_zero;
  logic          long_wait;
  logic [CW-1:0] cnt_dec;

  // A timed state of N cycles loads N-1 and leaves on the cycle the counter reads 0.
  function automatic logic [CW-1:0] load(input int n);
    load = CW'(n - 1);
  endfunction

  // Init command table: function set 8-bit/2-line, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  assign cnt_zero  = (cnt == '0);
  assign cnt_dec   = cnt - CW'(1);
  // Clear display and return home (0x01..0x03 as commands) need the long settle time.
  assign long_wait = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  assign o_ready     = (state == S_IDLE);
  assign o_init_done = init_done_q;
  assign o_lcd       = lcd_q;

  // State, counter, init index and captured byte registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_PWRUP;
      cnt         <= load(T_PWR);
      init_idx    <= 2'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      init_idx    <= init_idx_nxt;
      rs_q        <= rs_nxt;
      data_q      <= data_nxt;
      init_done_q <= init_done_nxt;
    end
  end

  // Next-state logic: walk SETUP->PULSE->HOLD->WAIT per byte, sequencing the init table first.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    init_idx_nxt  = init_idx;
    rs_nxt        = rs_q;
    data_nxt      = data_q;
    init_done_nxt = init_done_q;
    case (state)
      S_PWRUP: begin
        if (cnt_zero) begin
          state_nxt = S_SETUP;
          cnt_nxt   = load(T_SETUP);
          rs_nxt    = 1'b0;
          data_nxt  = init_cmd(init_idx);
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_nxt = S_PULSE;
          cnt_nxt   = load(T_PULSE);
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
      S_PULSE: begin
        if (cnt_zero) begin
          state_nxt = S_HOLD;
          cnt_nxt   = load(T_HOLD);
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_nxt = S_WAIT;
          cnt_nxt   = long_wait ? load(T_LONG) : load(T_CMD);
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
      S_WAIT: begin
        if (cnt_zero) begin
          if (init_done_q || init_idx == 2'd3) begin
            state_nxt     = S_IDLE;
            init_done_nxt = 1'b1;
          end else begin
            state_nxt    = S_SETUP;
            cnt_nxt      = load(T_SETUP);
            init_idx_nxt = init_idx + 2'd1;
            rs_nxt       = 1'b0;
            data_nxt     = init_cmd(init_idx + 2'd1);
          end
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
      S_IDLE: begin
        if (i_valid) begin
          state_nxt = S_SETUP;
          cnt_nxt   = load(T_SETUP);
          rs_nxt    = i_rs;
          data_nxt  = i_data;
        end
      end
      default: begin
        state_nxt = S_PWRUP;
        cnt_nxt   = load(T_PWR);
      end
    endcase
  end

  // Pin word is registered so the LCD sees glitch-free levels; it trails the state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd_q <= 32'h0;
    end else begin
      lcd_q <= {1'b1, 20'h0, (state == S_PULSE), rs_q, 1'b0, data_q};
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
module tb_lcd_ctrl;

  localparam int T_PWR   = 10;
  localparam int T_SETUP = 2;
  localparam int T_PULSE = 3;
  localparam int T_HOLD  = 2;
  localparam int T_CMD   = 5;
  localparam int T_LONG  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_rs = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        o_init_done;
  logic [31:0] o_lcd;

  lcd_ctrl #(
    .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE),
    .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_LONG(T_LONG)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs(i_rs), .i_data(i_data), .o_init_done(o_init_done), .o_lcd(o_lcd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Pulse monitor: records every EN pulse, the RS/DATA seen at its rise and whether they stayed put.
  typedef struct {
    int         rise;
    int         width;
    logic       rs;
    logic [7:0] data;
    logic       stable;
  } pulse_t;

  pulse_t pq[$];
  pulse_t np;
  logic   prev_en = 1'b0, prev_rdy = 1'b0, prev_done = 1'b0;
  int     rdy_rise = -1, done_rise = -1;
  int     viol = 0;

  always @(negedge clk) begin
    if (o_lcd[8] !== 1'b0 || o_lcd[30:11] !== 20'h0) viol++;
    if (o_lcd[10] && !prev_en) begin
      np.rise = cyc; np.width = -1; np.rs = o_lcd[9]; np.data = o_lcd[7:0]; np.stable = 1'b1;
      pq.push_back(np);
    end else if (o_lcd[10] && pq.size() > 0) begin
      if (o_lcd[9] !== pq[pq.size()-1].rs || o_lcd[7:0] !== pq[pq.size()-1].data)
        pq[pq.size()-1].stable = 1'b0;
    end
    if (!o_lcd[10] && prev_en && pq.size() > 0)
      pq[pq.size()-1].width = cyc - pq[pq.size()-1].rise;
    if (o_ready && !prev_rdy) rdy_rise = cyc;
    if (o_init_done && !prev_done) done_rise = cyc;
    prev_en = o_lcd[10];
    prev_rdy = o_ready;
    prev_done = o_init_done;
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         ready_dly;
  } vec_t;

  vec_t vecs[8];

  task automatic wait_ready(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (o_ready) break;
    end
    if (k == 200) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_rdy_after(input string name, input int after);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (rdy_rise > after) break;
    end
    if (k == 200) chk({name, "_ready_return_timeout"}, 0, 1);
  endtask

  task automatic accept(input logic rs, input logic [7:0] data, output int acc);
    wait_ready("accept");
    i_valid = 1'b1; i_rs = rs; i_data = data;
    @(posedge clk); #1;
    acc = cyc;
    i_valid = 1'b0;
  endtask

  task automatic release_reset(output int rel);
    @(negedge clk); #1;
    pq.delete(); rdy_rise = -1; done_rise = -1;
    rst = 1'b1;
    rel = cyc;
  endtask

  // Full power-up check relative to the release point.
  task automatic check_init(input string name, input int rel);
    int k;
    @(negedge clk); #1;
    chk({name, "_on_after_release"}, o_lcd[31], 1);
    for (k = 0; k < 500; k++) begin
      if (done_rise >= 0) break;
      @(negedge clk); #1;
    end
    if (k == 500) chk({name, "_init_timeout"}, 0, 1);
    chk({name, "_pulse_count"}, pq.size(), 4);
    if (pq.size() == 4) begin
      chk({name, "_cmd0"}, {pq[0].rs, pq[0].data}, {1'b0, 8'h38});
      chk({name, "_cmd1"}, {pq[1].rs, pq[1].data}, {1'b0, 8'h0C});
      chk({name, "_cmd2"}, {pq[2].rs, pq[2].data}, {1'b0, 8'h01});
      chk({name, "_cmd3"}, {pq[3].rs, pq[3].data}, {1'b0, 8'h06});
      for (int i = 0; i < 4; i++) begin
        chk({name, "_width"}, pq[i].width, 3);
        chk({name, "_stable"}, pq[i].stable, 1);
      end
      chk({name, "_first_rise"}, pq[0].rise - rel, T_PWR + T_SETUP + 1);
      chk({name, "_gap01"}, pq[1].rise - pq[0].rise, 12);
      chk({name, "_gap12"}, pq[2].rise - pq[1].rise, 12);
      chk({name, "_gap23_long"}, pq[3].rise - pq[2].rise, 27);
      chk({name, "_done_after_last"}, done_rise - pq[3].rise, 9);
    end
    chk({name, "_ready_with_done"}, rdy_rise, done_rise);
    chk({name, "_idle_word"}, o_lcd, 32'h8000_0006);
  endtask

  initial begin
    int rel, acc, acc2;

    vecs[0] = '{1'b1, 8'h41, 12};
    vecs[1] = '{1'b0, 8'h01, 27};
    vecs[2] = '{1'b0, 8'h02, 27};
    vecs[3] = '{1'b0, 8'h03, 27};
    vecs[4] = '{1'b0, 8'h04, 12};
    vecs[5] = '{1'b1, 8'h01, 12};
    vecs[6] = '{1'b0, 8'h00, 12};
    vecs[7] = '{1'b1, 8'hFF, 12};

    // Held in reset.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_lcd", o_lcd, 0);
    chk("reset_ready", o_ready, 0);
    chk("reset_done", o_init_done, 0);

    release_reset(rel);
    check_init("init", rel);

    // Table-driven single writes.
    foreach (vecs[i]) begin
      pq.delete(); rdy_rise = -1;
      accept(vecs[i].rs, vecs[i].data, acc);
      wait_rdy_after("vec", acc);
      chk("vec_pulse_count", pq.size(), 1);
      if (pq.size() == 1) begin
        chk("vec_en_rise", pq[0].rise - acc, T_SETUP + 1);
        chk("vec_en_width", pq[0].width, T_PULSE);
        chk("vec_rs_data", {pq[0].rs, pq[0].data}, {vecs[i].rs, vecs[i].data});
        chk("vec_stable", pq[0].stable, 1);
      end
      chk("vec_ready_return", rdy_rise - acc, vecs[i].ready_dly);
      chk("vec_idle_word", o_lcd, {1'b1, 20'h0, 1'b0, vecs[i].rs, 1'b0, vecs[i].data});
    end

    // Busy-time input is ignored; held valid is taken on the first IDLE cycle.
    pq.delete(); rdy_rise = -1;
    wait_ready("ign");
    i_valid = 1'b1; i_rs = 1'b1; i_data = 8'hA5;
    @(posedge clk); #1;
    acc = cyc;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (cyc == acc + 12) begin
        chk("ign_ready_first_idle", o_ready, 1);
        i_rs = 1'b1; i_data = 8'h5A;
        break;
      end
      i_data = 8'(cyc * 37 + 11);
      i_rs = cyc[0];
    end
    @(posedge clk); #1;
    acc2 = cyc;
    i_valid = 1'b0;
    chk("ign_accept_spacing", acc2 - acc, 13);
    chk("ign_busy_after_accept", o_ready, 0);
    wait_rdy_after("ign", acc2);
    chk("ign_pulse_count", pq.size(), 2);
    if (pq.size() == 2) begin
      chk("ign_first_byte", {pq[0].rs, pq[0].data}, {1'b1, 8'hA5});
      chk("ign_first_stable", pq[0].stable, 1);
      chk("ign_second_byte", {pq[1].rs, pq[1].data}, {1'b1, 8'h5A});
      chk("ign_second_rise", pq[1].rise - acc, 16);
    end

    // Reset asserted while EN is high.
    accept(1'b0, 8'h38, acc);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        @(negedge clk); #1;
        if (o_lcd[10]) break;
      end
      if (k == 50) chk("rstpulse_en_timeout", 0, 1);
    end
    rst = 1'b0;
    #1;
    chk("rstpulse_lcd", o_lcd, 0);
    chk("rstpulse_done", o_init_done, 0);
    chk("rstpulse_ready", o_ready, 0);
    repeat (2) @(posedge clk);
    release_reset(rel);
    check_init("reinit", rel);

    chk("rw_unused_bits_clean", viol, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
